simple_alu_initiator: RTL and testbench

Command-side master for the simple ALU port. It accepts one ALU command (2-bit opcode, two operands) from a local valid/ready source and serializes it onto the ALU's `opcode_valid`/`opcode`/`data` pins. It then waits for the ALU's `done` pulse and returns `result`/`overflow`, or a timeout flag, through a valid/ready response port. It is instantiated beside the ALU and drives the ALU's input pins directly.

---
 rtl/simple_alu_pkg.sv | 30 +++
 rtl/alu_wait_timer.sv | 46 ++++
 rtl/simple_alu_initiator.sv | 149 ++++++++++++++
 tb/tb_simple_alu_initiator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/simple_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_alu_pkg
// Description : Shared types for the simple ALU initiator and responder:
//               opcode encoding and the initiator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_alu_pkg;

    localparam int ALU_OP_BITS = 2;

    // Opcode encoding on the ALU port; the responder decodes the same values.
    typedef enum logic [ALU_OP_BITS-1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    // Command-side sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND0 = 3'd1,
        ST_SEND1 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } initiator_state_t;

endpackage : simple_alu_pkg
`default_nettype wire

// File: rtl/alu_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : alu_wait_timer
// Description : Clearable up-counter that flags "expired" when it reaches
//               TIMEOUT-1. It stops there rather than wrapping, so the flag
//               stays asserted until the next clear.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

    // Next count: clear has priority, otherwise count while enabled until expiry.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : alu_wait_timer
`default_nettype wire

// File: rtl/simple_alu_initiator.sv
`default_nettype none
// ============================================================================
// Module      : simple_alu_initiator
// Description : Command-side master for the simple ALU port. Takes one
//               command over valid/ready, serialises the opcode LSB first
//               with operand A then B, waits for the ALU done pulse (or a
//               timeout) and holds the response until it is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_alu_initiator
    import simple_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ALU_OP_BITS-1:0] cmd_op,
    input  logic [DATA_WIDTH-1:0]  cmd_a,
    input  logic [DATA_WIDTH-1:0]  cmd_b,
    output logic                   opcode_valid,
    output logic                   opcode,
    output logic [DATA_WIDTH-1:0]  data,
    input  logic                   done,
    input  logic [DATA_WIDTH-1:0]  result,
    input  logic                   overflow,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_result,
    output logic                   rsp_overflow,
    output logic                   rsp_timeout
);

    initiator_state_t        state_q, state_d;
    alu_op_t                 op_q, op_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                    rsp_overflow_q, rsp_overflow_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic [ALU_OP_BITS-1:0]  op_bits;
    logic                    timer_expired;

    assign op_bits = op_q;

    // Wait timer: cleared while sending the second beat so every WAIT entry starts at zero.
    alu_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_SEND1),
        .enable  (state_q == ST_WAIT),
        .expired (timer_expired)
    );

    // Next-state and response capture; done is only looked at in WAIT and wins over timeout.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_timeout_d  = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = alu_op_t'(cmd_op);
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    state_d = ST_SEND0;
                end
            end
            ST_SEND0: state_d = ST_SEND1;
            ST_SEND1: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done) begin
                    rsp_result_d   = result;
                    rsp_overflow_d = overflow;
                    rsp_timeout_d  = 1'b0;
                    state_d        = ST_RESP;
                end else if (timer_expired) begin
                    rsp_result_d   = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_timeout_d  = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU pin drive decoded purely from state and latched command.
    always_comb begin
        opcode_valid = 1'b0;
        opcode       = 1'b0;
        data         = '0;
        case (state_q)
            ST_SEND0: begin
                opcode_valid = 1'b1;
                opcode       = op_bits[0];
                data         = a_q;
            end
            ST_SEND1: begin
                opcode_valid = 1'b1;
                opcode       = op_bits[1];
                data         = b_q;
            end
            default: ;
        endcase
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_timeout  = rsp_timeout_q;

    // State, command and response registers; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= ALU_ADD;
            a_q            <= '0;
            b_q            <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_timeout_q  <= rsp_timeout_d;
        end
    end

endmodule : simple_alu_initiator
`default_nettype wire

// File: tb/tb_simple_alu_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_alu_initiator
// Description : Self-checking bench for simple_alu_initiator with a small
//               ALU model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_alu_initiator;
    import simple_alu_pkg::*;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          opcode_valid;
    logic          opcode;
    logic [DW-1:0] data;
    logic          done = 1'b0;
    logic [DW-1:0] result = '0;
    logic          overflow = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_timeout;

    typedef struct {
        logic [DW-1:0] res;
        logic          ovf;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    simple_alu_initiator #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .data         (data),
        .done         (done),
        .result       (result),
        .overflow     (overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU: {overflow, result}; overflow is signed overflow for ADD/SUB.
    function automatic logic [DW:0] alu_model(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          v;
        v = 1'b0;
        case (op)
            2'b00: begin r = a + b; v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            2'b01: begin r = a - b; v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            2'b10: r = a & b;
            default: r = a | b;
        endcase
        return {v, r};
    endfunction

    // One full command. k: WAIT cycle index in which done is pulsed (<0 never).
    // hold: cycles rsp_ready stays low with cmd_valid held high. early: pulse done in SEND0.
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int k, input int hold, input bit early);
        logic [DW:0] m;
        exp_t        e;
        exp_t        got;
        int          lat;
        int          exp_lat;
        bit          done_in_time;
        m = alu_model(op, a, b);
        done_in_time = (k >= 0) && (k < TO);
        if (done_in_time) e = '{res: m[DW-1:0], ovf: m[DW], tmo: 1'b0};
        else              e = '{res: '0, ovf: 1'b0, tmo: 1'b1};
        sb.push_back(e);
        exp_lat = done_in_time ? k + 1 : TO;

        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        check_eq("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("send0_pins", {opcode_valid, opcode, data}, {1'b1, op[0], a});
        check_eq("cmd_ready_busy", cmd_ready, 0);
        if (early) begin done = 1'b1; result = 8'h55; overflow = 1'b1; end
        @(negedge clk);
        done = 1'b0;
        check_eq("send1_pins", {opcode_valid, opcode, data}, {1'b1, op[1], b});
        @(negedge clk);
        check_eq("wait_pins", {opcode_valid, opcode, data}, 0);
        check_eq("wait_no_rsp", rsp_valid, 0);

        lat = 0;
        while (!rsp_valid && lat < TO + 8) begin
            done     = (lat == k);
            result   = (lat == k) ? m[DW-1:0] : 8'h00;
            overflow = (lat == k) ? m[DW] : 1'b0;
            @(negedge clk);
            lat++;
        end
        done = 1'b0;
        check_eq("rsp_valid", rsp_valid, 1);
        check_eq("rsp_latency", lat, exp_lat);

        if (sb.size() > 0) begin
            got = sb.pop_front();
            check_eq("rsp_result", rsp_result, got.res);
            check_eq("rsp_overflow", rsp_overflow, got.ovf);
            check_eq("rsp_timeout", rsp_timeout, got.tmo);
        end

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            check_eq("hold_rsp", {rsp_valid, rsp_timeout, rsp_overflow, rsp_result},
                     {1'b1, e.tmo, e.ovf, e.res});
            check_eq("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_rsp_cmd_ready", cmd_ready, 1);
        check_eq("post_rsp_valid", rsp_valid, 0);
    endtask

    initial begin
        bit late_rsp;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_pins", {opcode_valid, opcode, data}, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_timeout, rsp_overflow, rsp_result}, 0);

        run_cmd(ALU_ADD, 8'h05, 8'h03, 1, 0, 1'b0);
        run_cmd(ALU_SUB, 8'h7F, 8'hFF, 0, 0, 1'b0);
        run_cmd(ALU_OR,  8'h0F, 8'hF0, -1, 0, 1'b0);

        // Stray done while idle must not create a response.
        done = 1'b1; result = 8'h55;
        @(negedge clk);
        done = 1'b0; result = 8'h00;
        check_eq("idle_done_ignored", rsp_valid, 0);
        check_eq("idle_done_ready", cmd_ready, 1);

        run_cmd(ALU_AND, 8'hAA, 8'hFF, 3, 10, 1'b1);
        // done arriving on the very last WAIT cycle beats the timeout.
        run_cmd(ALU_ADD, 8'h10, 8'h20, TO - 1, 0, 1'b0);

        // Reset in the middle of WAIT drops the command.
        cmd_op = ALU_SUB; cmd_a = 8'h33; cmd_b = 8'h11; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("wrst_cmd_ready", cmd_ready, 1);
        check_eq("wrst_pins", {opcode_valid, opcode, data}, 0);
        check_eq("wrst_rsp", {rsp_valid, rsp_timeout, rsp_overflow, rsp_result}, 0);
        done = 1'b1; result = 8'hCC;
        @(negedge clk);
        done = 1'b0; result = 8'h00;
        late_rsp = 1'b0;
        for (int i = 0; i < TO + 4; i++) begin
            if (rsp_valid) late_rsp = 1'b1;
            @(negedge clk);
        end
        check_eq("late_done_no_rsp", late_rsp, 0);

        run_cmd(ALU_ADD, 8'hFF, 8'h01, 2, 0, 1'b0);
        check_eq("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_simple_alu_initiator
`default_nettype wire
